// File: rtl/bp_me_pkg.sv
// bp_me_pkg: shared types for the coherence wormhole transmit endpoint.
//   bp_coh_wh_header_s           header flit field order {payload, len, cord}
//                                (MSB first) at the default coh_noc widths
//   bp_coh_wh_tx_state_e         transmit FSM states
//   bsg_ready_and_link_sif_width width of a {v, ready_and_rev, data} link
//   ceil_div                     integer ceiling division
package bp_me_pkg;

  localparam int coh_noc_flit_width_gp = 64;
  localparam int coh_noc_cord_width_gp = 16;
  localparam int coh_noc_len_width_gp  = 4;

  // Header field order. Endpoints built at other widths use the same order.
  typedef struct packed {
    logic [coh_noc_flit_width_gp-coh_noc_cord_width_gp-coh_noc_len_width_gp-1:0] payload;
    logic [coh_noc_len_width_gp-1:0]  len;
    logic [coh_noc_cord_width_gp-1:0] cord;
  } bp_coh_wh_header_s;

  typedef enum logic {
    e_ready = 1'b0,
    e_send  = 1'b1
  } bp_coh_wh_tx_state_e;

  // Link layout, MSB first: v, ready_and_rev, data.
  function automatic int bsg_ready_and_link_sif_width(input int data_width);
    return data_width + 2;
  endfunction

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/bp_coh_flit_piso.sv
// bp_coh_flit_piso: holds one accepted message and presents the flit chosen
// by sel_i. Flit 0 is the header; flits 1..max_len_p are body slices of the
// payload, zero-padded above the payload width. A sel_i value beyond
// max_len_p yields an all-zero flit.
//   clk_i   clock
//   load_i  capture pkt_i/cord_i/len_i
//   pkt_i, cord_i, len_i  message fields to capture
//   sel_i   flit index to present
//   len_o   captured body-flit count
//   flit_o  selected flit
module bp_coh_flit_piso
  #(parameter int flit_width_p   = 64
  , parameter int cord_width_p   = 16
  , parameter int len_width_p    = 4
  , parameter int pkt_width_p    = 256
  , parameter int hdr_pl_width_p = 44
  , parameter int max_len_p      = 4
  )
  (input  logic                    clk_i
  , input  logic                    load_i
  , input  logic [pkt_width_p-1:0]  pkt_i
  , input  logic [cord_width_p-1:0] cord_i
  , input  logic [len_width_p-1:0]  len_i
  , input  logic [len_width_p-1:0]  sel_i
  , output logic [len_width_p-1:0]  len_o
  , output logic [flit_width_p-1:0] flit_o
  );

  localparam int pad_width_lp = hdr_pl_width_p + max_len_p * flit_width_p;

  logic [pkt_width_p-1:0]  pkt_q;
  logic [cord_width_p-1:0] cord_q;
  logic [len_width_p-1:0]  len_q;

  // Datapath only; the link valid is what resets, and data is masked by it.
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      pkt_q  <= pkt_i;
      cord_q <= cord_i;
      len_q  <= len_i;
    end
  end

  logic [pad_width_lp-1:0] pkt_pad;
  assign pkt_pad = pad_width_lp'(pkt_q);

  logic [flit_width_p-1:0] flits [max_len_p+1];
  assign flits[0] = {pkt_q[hdr_pl_width_p-1:0], len_q, cord_q};

  for (genvar gi = 1; gi <= max_len_p; gi++) begin : g_body
    assign flits[gi] = pkt_pad[hdr_pl_width_p + gi*flit_width_p - 1 -: flit_width_p];
  end

  always_comb begin
    flit_o = '0;
    for (int k = 0; k <= max_len_p; k++) begin
      if (sel_i == len_width_p'(k)) flit_o = flits[k];
    end
  end

  assign len_o = len_q;

endmodule

// File: rtl/bp_coh_wormhole_tx.sv
// bp_coh_wormhole_tx: accepts one coherence message per v_i/ready_and_o
// handshake, prepends a routing header flit {payload, len, cord} and
// serializes the message onto a ready-and wormhole link.
//   clk_i, reset_i   clock, synchronous active-high reset
//   pkt_i            message payload
//   dst_cord_i       destination {y,x}
//   len_i            body flit count (0 = header only)
//   v_i/ready_and_o  message handshake
//   link_i           link in; only ready_and_rev is used
//   link_o           link out; v and data driven, ready_and_rev tied 0
// Optional feature macro BP_COH_WH_TX_BYPASS_EN: when defined the header is
// built combinationally and sent in the same cycle as the input handshake.
module bp_coh_wormhole_tx
  import bp_me_pkg::*;
  #(parameter int flit_width_p = 64
  , parameter int cord_width_p = 16
  , parameter int len_width_p  = 4
  , parameter int pkt_width_p  = 256
  , localparam int hdr_pl_width_lp = flit_width_p - cord_width_p - len_width_p
  , localparam int max_len_lp      = ceil_div(pkt_width_p - hdr_pl_width_lp, flit_width_p)
  , localparam int link_width_lp   = bsg_ready_and_link_sif_width(flit_width_p)
  )
  (input  logic                     clk_i
  , input  logic                     reset_i
  , input  logic [pkt_width_p-1:0]   pkt_i
  , input  logic [cord_width_p-1:0]  dst_cord_i
  , input  logic [len_width_p-1:0]   len_i
  , input  logic                     v_i
  , output logic                     ready_and_o
  , input  logic [link_width_lp-1:0] link_i
  , output logic [link_width_lp-1:0] link_o
  );

  bp_coh_wh_tx_state_e state_q, state_d;
  logic [len_width_p-1:0] cnt_q, cnt_d;

  logic                    link_ready;
  logic                    link_v;
  logic [flit_width_p-1:0] link_data;
  logic                    load;
  logic [len_width_p-1:0]  len_q;
  logic [flit_width_p-1:0] piso_flit;

  assign link_ready = link_i[flit_width_p];

  logic unused_link;
  assign unused_link = ^{link_i[link_width_lp-1], link_i[flit_width_p-1:0]};

`ifdef BP_COH_WH_TX_BYPASS_EN
  logic [flit_width_p-1:0] hdr_in;
  assign hdr_in = {pkt_i[hdr_pl_width_lp-1:0], len_i, dst_cord_i};
`endif

  bp_coh_flit_piso
    #(.flit_width_p(flit_width_p), .cord_width_p(cord_width_p)
    , .len_width_p(len_width_p), .pkt_width_p(pkt_width_p)
    , .hdr_pl_width_p(hdr_pl_width_lp), .max_len_p(max_len_lp))
    piso
    (.clk_i(clk_i)
    , .load_i(load)
    , .pkt_i(pkt_i)
    , .cord_i(dst_cord_i)
    , .len_i(len_i)
    , .sel_i(cnt_q)
    , .len_o(len_q)
    , .flit_o(piso_flit)
    );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load        = 1'b0;
    ready_and_o = 1'b0;
    link_v      = 1'b0;
    link_data   = '0;
    unique case (state_q)
      e_ready: begin
`ifdef BP_COH_WH_TX_BYPASS_EN
        ready_and_o = link_ready;
        link_v      = v_i;
        link_data   = v_i ? hdr_in : '0;
        // Header already went out this cycle; resume at the first body flit.
        if (v_i && link_ready && (len_i != '0)) begin
          load    = 1'b1;
          cnt_d   = len_width_p'(1);
          state_d = e_send;
        end
`else
        ready_and_o = 1'b1;
        if (v_i) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = e_send;
        end
`endif
      end
      e_send: begin
        link_v    = 1'b1;
        link_data = piso_flit;
        if (link_ready) begin
          if (cnt_q == len_q) begin
            // Final flit leaving: take the next message without a bubble.
            ready_and_o = 1'b1;
            cnt_d       = '0;
            if (v_i) load = 1'b1;
            else     state_d = e_ready;
          end else begin
            cnt_d = cnt_q + len_width_p'(1);
          end
        end
      end
      default: state_d = e_ready;
    endcase
    // Reset silences the link and refuses input for its whole duration.
    if (reset_i) begin
      ready_and_o = 1'b0;
      link_v      = 1'b0;
      link_data   = '0;
      load        = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_ready;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign link_o = {link_v, 1'b0, link_data};

  // Lengths beyond the payload capacity are a sender bug.
  always_ff @(posedge clk_i) begin
    if (!reset_i && v_i && ready_and_o) begin
      assert (len_i <= len_width_p'(max_len_lp));
    end
  end

endmodule

// File: tb/tb_bp_coh_wormhole_tx.sv
module tb_bp_coh_wormhole_tx;

  localparam int FW  = 32;
  localparam int CW  = 8;
  localparam int LW  = 4;
  localparam int PW  = 100;
  localparam int HPL = 20;
  localparam int ML  = 3;
  localparam int LKW = FW + 2;

  logic           clk = 1'b0;
  logic           reset_i;
  logic [PW-1:0]  pkt_i;
  logic [CW-1:0]  cord_i;
  logic [LW-1:0]  len_i;
  logic           v_i;
  logic           ready_and_o;
  logic [LKW-1:0] link_i;
  logic [LKW-1:0] link_o;
  logic           link_rdy;

  assign link_i = {1'b0, link_rdy, {FW{1'b0}}};

  always #5 clk = ~clk;

  bp_coh_wormhole_tx #(.flit_width_p(FW), .cord_width_p(CW), .len_width_p(LW), .pkt_width_p(PW)) dut
    (.clk_i(clk), .reset_i(reset_i), .pkt_i(pkt_i), .dst_cord_i(cord_i), .len_i(len_i)
    , .v_i(v_i), .ready_and_o(ready_and_o), .link_i(link_i), .link_o(link_o));

  int checks = 0;
  int errors = 0;

  // Reference model: flits still owed to the link, oldest first.
  logic [FW-1:0] q[$];
  logic          obs_v, obs_ready;
  logic [FW-1:0] obs_data;
  bit            rst_prev = 1'b0;
  int            n_valid = 0;
  int            cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] flit_of(input logic [PW-1:0] p, input logic [CW-1:0] c,
                                            input logic [LW-1:0] l, input int k);
    logic [PW-1:0] s;
    if (k == 0) return {p[HPL-1:0], l, c};
    s = p >> (HPL + (k - 1) * FW);
    return s[FW-1:0];
  endfunction

  // One clock: sample and check at negedge, update the model, advance.
  task automatic tick();
    bit exp_ready;
    @(negedge clk);
    obs_v     = link_o[FW+1];
    obs_ready = ready_and_o;
    obs_data  = link_o[FW-1:0];
    if (obs_v) n_valid++;
    if (reset_i) begin
      chk("ready_in_reset", 64'(obs_ready), 64'(0));
      if (rst_prev) chk("link_in_reset", 64'(link_o), 64'(0));
      q.delete();
    end else begin
      exp_ready = (q.size() == 0) || (q.size() == 1 && link_rdy);
      chk("ready", 64'(obs_ready), 64'(exp_ready));
      chk("link_v", 64'(obs_v), 64'(q.size() != 0));
      chk("link_rev", 64'(link_o[FW]), 64'(0));
      if (q.size() != 0) chk("link_data", 64'(obs_data), 64'(q[0]));
      if (q.size() != 0 && link_rdy) void'(q.pop_front());
      if (v_i && exp_ready)
        for (int k = 0; k <= int'(len_i); k++) q.push_back(flit_of(pkt_i, cord_i, len_i, k));
    end
    rst_prev = reset_i;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  typedef struct {
    logic [PW-1:0] pkt;
    logic [CW-1:0] cord;
    logic [LW-1:0] len;
    logic [FW-1:0] exp [4];
  } vec_t;

  vec_t tbl [4];
  int   exp_r [6];
  int   exp_vv [6];
  logic [127:0] rnd;

  initial begin
    tbl[0].pkt = 100'h0_DEAD_BEEF_CAFE_F00D_1234_5; tbl[0].cord = 8'h21; tbl[0].len = 4'd3;
    tbl[0].exp[0] = 32'h1234_5321; tbl[0].exp[1] = 32'hCAFE_F00D;
    tbl[0].exp[2] = 32'hDEAD_BEEF; tbl[0].exp[3] = 32'h0000_0000;
    tbl[1].pkt = 100'hF_0123_4567_89AB_CDEF_0011_2233; tbl[1].cord = 8'h7E; tbl[1].len = 4'd3;
    tbl[1].exp[0] = 32'h1223_337E; tbl[1].exp[1] = 32'hBCDE_F001;
    tbl[1].exp[2] = 32'h3456_789A; tbl[1].exp[3] = 32'h0000_F012;
    tbl[2].pkt = tbl[1].pkt; tbl[2].cord = 8'h33; tbl[2].len = 4'd1;
    tbl[2].exp[0] = 32'h1223_3133; tbl[2].exp[1] = 32'hBCDE_F001;
    tbl[2].exp[2] = 32'h0; tbl[2].exp[3] = 32'h0;
    tbl[3].pkt = tbl[1].pkt; tbl[3].cord = 8'h05; tbl[3].len = 4'd0;
    tbl[3].exp[0] = 32'h1223_3005; tbl[3].exp[1] = 32'h0;
    tbl[3].exp[2] = 32'h0; tbl[3].exp[3] = 32'h0;

    reset_i = 1'b1; v_i = 1'b0; link_rdy = 1'b1;
    pkt_i = '0; cord_i = '0; len_i = '0;
    #1;
    repeat (3) tick();
    reset_i = 1'b0;
    tick();
    chk("ready_first_after_reset", 64'(obs_ready), 64'(1));
    chk("v_first_after_reset", 64'(obs_v), 64'(0));

    // Directed vectors with hand-derived flits.
    for (int i = 0; i < 4; i++) begin
      pkt_i = tbl[i].pkt; cord_i = tbl[i].cord; len_i = tbl[i].len; v_i = 1'b1;
      tick();
      chk("tbl_accept", 64'(obs_ready), 64'(1));
      v_i = 1'b0;
      for (int k = 0; k <= int'(tbl[i].len); k++) begin
        tick();
        chk("tbl_flit_v", 64'(obs_v), 64'(1));
        chk("tbl_flit_data", 64'(obs_data), 64'(tbl[i].exp[k]));
      end
      tick();
      chk("tbl_idle_v", 64'(obs_v), 64'(0));
      chk("tbl_idle_ready", 64'(obs_ready), 64'(1));
    end

    // Backpressure: 3 stalled cycles on flit 1 stretch the packet to 7 cycles.
    pkt_i = tbl[0].pkt; cord_i = tbl[0].cord; len_i = 4'd3; v_i = 1'b1;
    tick();
    v_i = 1'b0; n_valid = 0;
    tick();
    link_rdy = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_data", 64'(obs_data), 64'(32'hCAFE_F00D));
      chk("stall_ready", 64'(obs_ready), 64'(0));
    end
    link_rdy = 1'b1;
    repeat (4) tick();
    chk("stall_cycles", 64'(n_valid), 64'(7));

    // Back-to-back len=1 messages with v_i held high.
    exp_r  = '{1, 0, 1, 0, 1, 1};
    exp_vv = '{0, 1, 1, 1, 1, 0};
    pkt_i = tbl[2].pkt; cord_i = tbl[2].cord; len_i = 4'd1; v_i = 1'b1;
    for (int t = 0; t < 6; t++) begin
      if (t == 3) v_i = 1'b0;
      tick();
      chk("b2b_ready", 64'(obs_ready), 64'(exp_r[t]));
      chk("b2b_v", 64'(obs_v), 64'(exp_vv[t]));
    end

    // Reset in the middle of a packet.
    pkt_i = tbl[0].pkt; cord_i = tbl[0].cord; len_i = 4'd3; v_i = 1'b1;
    tick();
    v_i = 1'b0;
    tick();
    reset_i = 1'b1;
    tick();
    tick();
    chk("rst_mid_v", 64'(obs_v), 64'(0));
    reset_i = 1'b0;
    tick();
    chk("rst_after_ready", 64'(obs_ready), 64'(1));
    chk("rst_after_v", 64'(obs_v), 64'(0));
    pkt_i = tbl[1].pkt; cord_i = tbl[1].cord; len_i = 4'd3; v_i = 1'b1;
    tick();
    v_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst_new_pkt", 64'(obs_data), 64'(tbl[1].exp[k]));
    end
    tick();

    // Randomized traffic against the queue model.
    for (int r = 0; r < 600; r++) begin
      rnd      = {$urandom, $urandom, $urandom, $urandom};
      pkt_i    = rnd[PW-1:0];
      cord_i   = CW'($urandom);
      len_i    = LW'($urandom_range(0, ML));
      v_i      = ($urandom % 2) == 0;
      link_rdy = ($urandom % 4) != 0;
      tick();
    end
    v_i = 1'b0; link_rdy = 1'b1;
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
